jesd204_versal_gt_adapter_rx: RTL and testbench

Receive-side adapter between the Versal GT RX 64b66b gearbox interface and the JESD204C link-layer RX core. It bit-reverses the 64-bit data word and the 2-bit sync header to restore link-layer bit order. It also runs the 64b66b block-synchronisation state machine, pulsing `rxgearboxslip` toward the GT until header lock is reached and then monitoring lock. Outputs are registered; `rx_block_sync` qualifies data toward the link layer.

---
 rtl/jesd204_versal_gt_adapter_rx.sv | 245 ++++++++++++++++++++++++
 tb/tb_jesd204_versal_gt_adapter_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204_versal_gt_adapter_rx.sv
//------------------------------------------------------------------------------
// jesd204_versal_gt_adapter_rx
//
// Receive-side adapter between the Versal GT RX 64b66b gearbox interface and
// the JESD204C link-layer RX core.
//   * Restores link-layer bit order: the 64-bit data word and the 2-bit sync
//     header are bit-reversed and registered (1 cycle latency).
//   * Runs 64b66b block synchronisation: while hunting, every bad sync header
//     requests a single-cycle gearbox slip, followed by a settling period in
//     which headers are ignored. After SH_LOCK_CNT consecutive good headers the
//     block is LOCKED. In LOCKED, headers are monitored in windows of
//     SH_LOCK_CNT events; SH_ERR_MAX bad headers inside one window drop lock
//     and trigger a new slip.
//
// Parameters:
//   SH_LOCK_CNT   good headers needed for lock / monitor window size
//   SH_ERR_MAX    bad headers per window that cause loss of lock
//   SLIP_WAIT     cycles after a slip pulse during which headers are ignored
//
// Ports:
//   usr_clk        in   GT user clock (only clock)
//   reset          in   synchronous active-high reset
//   rxdata         in   GT RX data, [63:0] used
//   rxheader       in   GT RX sync header, [1:0] used
//   rxdatavalid    in   GT data valid, [0] used
//   rxheadervalid  in   GT header valid, [0] used
//   rxgearboxslip  out  single-cycle slip request to the GT
//   rx_data        out  bit-reversed data word
//   rx_header      out  bit-swapped sync header
//   rx_valid       out  registered rxdatavalid[0]
//   rx_block_sync  out  high while block lock is held
//------------------------------------------------------------------------------
module jesd204_versal_gt_adapter_rx #(
    parameter int SH_LOCK_CNT = 64,
    parameter int SH_ERR_MAX  = 16,
    parameter int SLIP_WAIT   = 32
) (
    input  logic         usr_clk,
    input  logic         reset,
    input  logic [127:0] rxdata,
    input  logic [5:0]   rxheader,
    input  logic [1:0]   rxdatavalid,
    input  logic [1:0]   rxheadervalid,
    output logic         rxgearboxslip,
    output logic [63:0]  rx_data,
    output logic [1:0]   rx_header,
    output logic         rx_valid,
    output logic         rx_block_sync
);

    localparam int SH_W   = $clog2(SH_LOCK_CNT + 1);
    localparam int ERR_W  = $clog2(SH_ERR_MAX + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [SH_W-1:0]   SH_TARGET   = SH_W'(SH_LOCK_CNT);
    localparam logic [ERR_W-1:0]  ERR_TARGET  = ERR_W'(SH_ERR_MAX);
    localparam logic [WAIT_W-1:0] WAIT_TARGET = WAIT_W'(SLIP_WAIT);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // Mirror the data word: bit i lands at position 63-i.
    function automatic logic [63:0] bit_reverse64(input logic [63:0] d);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 64; i++) begin
            r[63-i] = d[i];
        end
        return r;
    endfunction

    // A 64b66b sync header is valid only as 01 or 10, i.e. odd parity.
    function automatic logic header_is_good(input logic [1:0] hdr);
        return ^hdr;
    endfunction

    state_t              state_r;
    logic [SH_W-1:0]     sh_cnt_r;
    logic [ERR_W-1:0]    err_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                slip_r;
    logic                block_sync_r;
    logic [63:0]         rx_data_r;
    logic [1:0]          rx_header_r;
    logic                rx_valid_r;

    logic                hdr_event_s;
    logic                hdr_good_s;
    logic [SH_W-1:0]     sh_cnt_inc_s;
    logic [ERR_W-1:0]    err_cnt_inc_s;
    logic [WAIT_W-1:0]   wait_cnt_inc_s;

    // Upper GT lanes are not used by this 64b66b configuration.
    logic                unused_s;
    assign unused_s = ^{rxdata[127:64], rxheader[5:2], rxdatavalid[1], rxheadervalid[1]};

    // Header classification and saturating counter increments.
    always_comb begin
        hdr_event_s = rxheadervalid[0];
        hdr_good_s  = header_is_good(rxheader[1:0]);

        if (sh_cnt_r == SH_TARGET) begin
            sh_cnt_inc_s = sh_cnt_r;
        end else begin
            sh_cnt_inc_s = sh_cnt_r + SH_W'(1);
        end

        if (err_cnt_r == ERR_TARGET) begin
            err_cnt_inc_s = err_cnt_r;
        end else begin
            err_cnt_inc_s = err_cnt_r + ERR_W'(1);
        end

        if (wait_cnt_r == WAIT_TARGET) begin
            wait_cnt_inc_s = wait_cnt_r;
        end else begin
            wait_cnt_inc_s = wait_cnt_r + WAIT_W'(1);
        end
    end

    // Registered data path: bit-order restoration, independent of valid.
    always_ff @(posedge usr_clk) begin
        if (reset) begin
            rx_data_r   <= 64'd0;
            rx_header_r <= 2'b00;
            rx_valid_r  <= 1'b0;
        end else begin
            rx_data_r   <= bit_reverse64(rxdata[63:0]);
            rx_header_r <= {rxheader[0], rxheader[1]};
            rx_valid_r  <= rxdatavalid[0];
        end
    end

    // Block-sync FSM with counters; slip and lock flags are set on the edge
    // that enters SLIP / LOCKED so they line up with the state itself.
    always_ff @(posedge usr_clk) begin
        if (reset) begin
            state_r      <= ST_HUNT;
            sh_cnt_r     <= '0;
            err_cnt_r    <= '0;
            wait_cnt_r   <= '0;
            slip_r       <= 1'b0;
            block_sync_r <= 1'b0;
        end else begin
            case (state_r)
                ST_HUNT: begin
                    slip_r       <= 1'b0;
                    block_sync_r <= 1'b0;
                    if (hdr_event_s) begin
                        if (!hdr_good_s) begin
                            state_r    <= ST_SLIP;
                            sh_cnt_r   <= '0;
                            err_cnt_r  <= '0;
                            wait_cnt_r <= '0;
                            slip_r     <= 1'b1;
                        end else if (sh_cnt_inc_s == SH_TARGET) begin
                            state_r      <= ST_LOCKED;
                            sh_cnt_r     <= '0;
                            err_cnt_r    <= '0;
                            wait_cnt_r   <= '0;
                            block_sync_r <= 1'b1;
                        end else begin
                            sh_cnt_r <= sh_cnt_inc_s;
                        end
                    end else begin
                        sh_cnt_r <= sh_cnt_r;
                    end
                end

                // The slip pulse is one cycle wide; headers are ignored.
                ST_SLIP: begin
                    state_r      <= ST_WAIT;
                    sh_cnt_r     <= '0;
                    err_cnt_r    <= '0;
                    wait_cnt_r   <= '0;
                    slip_r       <= 1'b0;
                    block_sync_r <= 1'b0;
                end

                // Settling time counts clock cycles, not header events.
                ST_WAIT: begin
                    slip_r       <= 1'b0;
                    block_sync_r <= 1'b0;
                    if (wait_cnt_inc_s == WAIT_TARGET) begin
                        state_r    <= ST_HUNT;
                        sh_cnt_r   <= '0;
                        err_cnt_r  <= '0;
                        wait_cnt_r <= '0;
                    end else begin
                        wait_cnt_r <= wait_cnt_inc_s;
                    end
                end

                // Loss of lock is tested before window completion so the
                // last bad header of a full window still drops lock.
                ST_LOCKED: begin
                    slip_r       <= 1'b0;
                    block_sync_r <= 1'b1;
                    if (hdr_event_s) begin
                        if (!hdr_good_s && (err_cnt_inc_s == ERR_TARGET)) begin
                            state_r      <= ST_SLIP;
                            sh_cnt_r     <= '0;
                            err_cnt_r    <= '0;
                            wait_cnt_r   <= '0;
                            slip_r       <= 1'b1;
                            block_sync_r <= 1'b0;
                        end else if (sh_cnt_inc_s == SH_TARGET) begin
                            sh_cnt_r  <= '0;
                            err_cnt_r <= '0;
                        end else begin
                            sh_cnt_r <= sh_cnt_inc_s;
                            if (!hdr_good_s) begin
                                err_cnt_r <= err_cnt_inc_s;
                            end else begin
                                err_cnt_r <= err_cnt_r;
                            end
                        end
                    end else begin
                        sh_cnt_r <= sh_cnt_r;
                    end
                end

                default: begin
                    state_r      <= ST_HUNT;
                    sh_cnt_r     <= '0;
                    err_cnt_r    <= '0;
                    wait_cnt_r   <= '0;
                    slip_r       <= 1'b0;
                    block_sync_r <= 1'b0;
                end
            endcase
        end
    end

    assign rxgearboxslip = slip_r;
    assign rx_block_sync = block_sync_r;
    assign rx_data       = rx_data_r;
    assign rx_header     = rx_header_r;
    assign rx_valid      = rx_valid_r;

endmodule

// File: tb/tb_jesd204_versal_gt_adapter_rx.sv
//------------------------------------------------------------------------------
// Testbench for jesd204_versal_gt_adapter_rx: directed header sequences, a
// cycle-level behavioural model of block sync, and literal checkpoints.
//------------------------------------------------------------------------------
module tb_jesd204_versal_gt_adapter_rx;

    localparam int LOCK = 64;
    localparam int ERRM = 16;
    localparam int SW   = 32;

    logic         usr_clk = 1'b0;
    logic         reset;
    logic [127:0] rxdata;
    logic [5:0]   rxheader;
    logic [1:0]   rxdatavalid;
    logic [1:0]   rxheadervalid;
    logic         rxgearboxslip;
    logic [63:0]  rx_data;
    logic [1:0]   rx_header;
    logic         rx_valid;
    logic         rx_block_sync;

    always #5 usr_clk = ~usr_clk;

    jesd204_versal_gt_adapter_rx #(
        .SH_LOCK_CNT(LOCK),
        .SH_ERR_MAX (ERRM),
        .SLIP_WAIT  (SW)
    ) dut (
        .usr_clk      (usr_clk),
        .reset        (reset),
        .rxdata       (rxdata),
        .rxheader     (rxheader),
        .rxdatavalid  (rxdatavalid),
        .rxheadervalid(rxheadervalid),
        .rxgearboxslip(rxgearboxslip),
        .rx_data      (rx_data),
        .rx_header    (rx_header),
        .rx_valid     (rx_valid),
        .rx_block_sync(rx_block_sync)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: streak of good headers while hunting, a countdown of
    // ignored cycles after a slip, and a per-window event/bad tally when locked.
    bit          model_on = 1'b0;
    bit          m_locked;
    int          m_streak, m_ignore, m_win_ev, m_win_bad;
    logic [63:0] e_data;
    logic [1:0]  e_hdr;
    logic        e_valid, e_slip, e_sync;

    task automatic model_step(input logic rst, input logic [127:0] d, input logic [5:0] h,
                              input logic [1:0] dv, input logic [1:0] hv);
        logic [63:0] lo;
        logic [1:0]  hh;
        bit          good, start_slip;
        lo = d[63:0];
        hh = h[1:0];
        start_slip = 1'b0;
        if (rst) begin
            m_locked = 1'b0; m_streak = 0; m_ignore = 0; m_win_ev = 0; m_win_bad = 0;
            e_data = 64'd0; e_hdr = 2'b00; e_valid = 1'b0; e_slip = 1'b0; e_sync = 1'b0;
        end else begin
            e_data  = {<<{lo}};
            e_hdr   = {<<{hh}};
            e_valid = dv[0];
            good    = (hh == 2'b01) || (hh == 2'b10);
            if (m_ignore > 0) begin
                m_ignore--;
            end else if (hv[0]) begin
                if (m_locked) begin
                    m_win_ev++;
                    if (!good) m_win_bad++;
                    if (!good && m_win_bad == ERRM) begin
                        m_locked = 1'b0;
                        start_slip = 1'b1;
                    end else if (m_win_ev == LOCK) begin
                        m_win_ev = 0;
                        m_win_bad = 0;
                    end
                end else if (good) begin
                    m_streak++;
                    if (m_streak == LOCK) begin
                        m_locked = 1'b1;
                        m_streak = 0; m_win_ev = 0; m_win_bad = 0;
                    end
                end else begin
                    start_slip = 1'b1;
                end
            end
            if (start_slip) begin
                m_ignore = SW + 1;
                m_streak = 0; m_win_ev = 0; m_win_bad = 0;
            end
            e_slip = start_slip;
            e_sync = m_locked;
        end
    endtask

    // Compare process: every cycle, on the falling edge.
    always @(negedge usr_clk) begin
        if (model_on) begin
            check("rx_data",       rx_data,       e_data);
            check("rx_header",     64'(rx_header), 64'(e_hdr));
            check("rx_valid",      64'(rx_valid),  64'(e_valid));
            check("rxgearboxslip", 64'(rxgearboxslip), 64'(e_slip));
            check("rx_block_sync", 64'(rx_block_sync), 64'(e_sync));
        end
    end

    // One clock: drive inputs, let the edge pass, update the model, then
    // settle 1 time unit so literal checks see the post-edge outputs.
    task automatic step_d(input logic [127:0] d, input logic [5:0] h,
                          input logic [1:0] dv, input logic [1:0] hv);
        rxdata = d; rxheader = h; rxdatavalid = dv; rxheadervalid = hv;
        @(posedge usr_clk);
        model_step(reset, rxdata, rxheader, rxdatavalid, rxheadervalid);
        model_on = 1'b1;
        #1;
        cyc++;
    endtask

    task automatic step(input logic [1:0] hdr, input logic hv);
        step_d({$urandom, $urandom, $urandom, $urandom}, {4'($urandom), hdr},
               2'($urandom), {1'($urandom), hv});
    endtask

    int slips, last_slip, p3, lock_cyc, min_gap, pulses;

    initial begin
        reset = 1'b1;
        rxdata = '0; rxheader = '0; rxdatavalid = '0; rxheadervalid = '0;
        step(2'b01, 1'b1);
        step(2'b10, 1'b1);
        check("reset_data",  rx_data, 64'd0);
        check("reset_sync",  64'(rx_block_sync), 64'd0);
        check("reset_slip",  64'(rxgearboxslip), 64'd0);
        reset = 1'b0;

        // Bit order; upper lanes carry junk, no header event.
        step_d({64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_0001}, 6'b111101, 2'b01, 2'b10);
        check("bitorder_data", rx_data, 64'h8000_0000_0000_0000);
        check("bitorder_hdr",  64'(rx_header), 64'd2);
        check("bitorder_valid", 64'(rx_valid), 64'd1);

        // Clean lock: rises exactly after the 64th good header.
        for (int i = 0; i < LOCK; i++) begin
            step(2'b01, 1'b1);
            check("clean_no_slip", 64'(rxgearboxslip), 64'd0);
            if (i == LOCK - 2) check("clean_not_yet", 64'(rx_block_sync), 64'd0);
            if (i == LOCK - 1) check("clean_locked",  64'(rx_block_sync), 64'd1);
        end

        // Tolerance: 15 bad per window over 10 windows.
        for (int w = 0; w < 10; w++) begin
            for (int e = 0; e < LOCK; e++) step((e < ERRM - 1) ? 2'b11 : 2'b10, 1'b1);
            check("tolerate_window", 64'(rx_block_sync), 64'd1);
        end
        // 16 bad in one window: drop and slip on the following cycle.
        for (int e = 0; e < ERRM; e++) step((e % 2 == 0) ? 2'b00 : 2'b11, 1'b1);
        check("loss_sync", 64'(rx_block_sync), 64'd0);
        check("loss_slip", 64'(rxgearboxslip), 64'd1);
        step(2'b00, 1'b1);
        check("loss_slip_once", 64'(rxgearboxslip), 64'd0);
        for (int i = 0; i < SW; i++) step(2'b00, 1'b1);   // ignored cycles
        for (int i = 0; i < LOCK; i++) step(2'b10, 1'b1);
        check("relock", 64'(rx_block_sync), 64'd1);

        // 16th bad landing as the 64th event: loss of lock wins.
        for (int e = 0; e < LOCK; e++) step((e < LOCK - ERRM) ? 2'b01 : 2'b00, 1'b1);
        check("lastev_sync", 64'(rx_block_sync), 64'd0);
        check("lastev_slip", 64'(rxgearboxslip), 64'd1);
        for (int i = 0; i < SW + 1; i++) step(2'b11, 1'b1);

        // Hunt fail: 63 good + bad; the 33 ignored good headers must not count.
        for (int i = 0; i < LOCK - 1; i++) step(2'b01, 1'b1);
        step(2'b00, 1'b1);
        check("hunt_fail_slip", 64'(rxgearboxslip), 64'd1);
        pulses = 0;
        for (int i = 0; i < SW + 1; i++) begin
            step(2'b01, 1'b1);
            if (rxgearboxslip) pulses++;
        end
        check("hunt_fail_single_pulse", 64'(pulses), 64'd0);
        for (int i = 0; i < LOCK; i++) begin
            step(2'b01, 1'b1);
            if (i == LOCK - 2) check("hunt_restart_not_yet", 64'(rx_block_sync), 64'd0);
        end
        check("hunt_restart_locked", 64'(rx_block_sync), 64'd1);

        // Reset while locked.
        reset = 1'b1;
        step(2'b01, 1'b1);
        check("rst_locked_sync", 64'(rx_block_sync), 64'd0);
        check("rst_locked_data", rx_data, 64'd0);
        check("rst_locked_valid", 64'(rx_valid), 64'd0);
        reset = 1'b0;

        // 50% header-valid gaps: 64th valid header at cycle 126.
        for (int i = 0; i < 2 * LOCK; i++) begin
            step(2'b01, (i % 2) == 0);
            if (i == 2 * LOCK - 4) check("gap_not_yet", 64'(rx_block_sync), 64'd0);
            if (i == 2 * LOCK - 2) check("gap_locked",  64'(rx_block_sync), 64'd1);
        end

        // Reset during a slip pulse.
        reset = 1'b1; step(2'b01, 1'b1); reset = 1'b0;
        step(2'b11, 1'b1);
        check("pulse_before_rst", 64'(rxgearboxslip), 64'd1);
        reset = 1'b1;
        step(2'b00, 1'b1);
        check("pulse_truncated", 64'(rxgearboxslip), 64'd0);
        reset = 1'b0;

        // Slip convergence: GT aligns after 3 slips; WAIT sees header gaps.
        slips = 0; last_slip = -1000; min_gap = 1000; p3 = 0; lock_cyc = -1;
        for (int i = 0; i < 600 && lock_cyc < 0; i++) begin
            if (slips < 3) step((i % 2 == 0) ? 2'b00 : 2'b11, 1'b1);
            else step(2'b01, (cyc - p3 < SW + 1) ? 1'($urandom) : 1'b1);
            if (rxgearboxslip) begin
                if (cyc - last_slip < min_gap) min_gap = cyc - last_slip;
                last_slip = cyc;
                slips++;
                if (slips == 3) p3 = cyc;
            end
            if (rx_block_sync) lock_cyc = cyc;
        end
        check("conv_slips", 64'(slips), 64'd3);
        check("conv_gap_ok", 64'(min_gap >= SW + 2), 64'd1);
        check("conv_lock_latency", 64'(lock_cyc - p3), 64'(SW + 1 + LOCK));

        step(2'b01, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
